// File: rtl/prog_loader_if.sv
// Byte stream in from the UART receiver and instruction-memory write port out.
// The loader takes the master side; the environment or memory takes the slave side.
interface prog_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        inst_mem_wr_en;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_data;

    modport master (
        input  rx_data,
        input  rx_valid,
        output inst_mem_wr_en,
        output inst_mem_addr,
        output inst_mem_data
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  inst_mem_wr_en,
        input  inst_mem_addr,
        input  inst_mem_data
    );
endinterface

// File: rtl/prog_loader.sv
// Assembles big-endian 32-bit words from UART bytes and writes them to instruction memory.
// The CPU is held in reset until the HALT word has been stored.
module prog_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    parameter logic [7:0]  CMD_LOAD  = 8'h4C
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.master bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StError} state_e;

    state_e          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]     shift_q, shift_d;
    logic            word_rdy_q, word_rdy_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            rx_cmd;

    assign rx_cmd = bus.rx_valid && (bus.rx_data == CMD_LOAD);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        word_rdy_d = 1'b0;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (rx_cmd) begin
                    state_d    = StLoad;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    addr_d     = '0;
                end
            end
            StLoad: begin
                // Word completed last cycle: issue the write while new bytes keep shifting in.
                if (word_rdy_q) begin
                    wr_en_d    = 1'b1;
                    addr_d     = 32'(word_cnt_q) << 2;
                    data_d     = shift_q;
                    word_cnt_d = word_cnt_q + CntW'(1);
                end
                if (bus.rx_valid) begin
                    shift_d    = {shift_q[23:0], bus.rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_rdy_d = (byte_cnt_q == 2'd3);
                end
                // Exit is decided in the cycle after the write pulse.
                if (wr_en_q) begin
                    if (data_q == HALT_WORD) begin
                        state_d = StDone;
                    end else if (word_cnt_q == CntW'(MAX_WORDS)) begin
                        state_d = StError;
                    end
                end
                if (state_d != StLoad) begin
                    byte_cnt_d = 2'd0;
                    shift_d    = '0;
                    word_rdy_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            word_rdy_q <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            word_rdy_q <= word_rdy_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cpu_reset  <= (state_d != StDone);
            busy       <= (state_d == StLoad);
            done       <= (state_d == StDone);
            err        <= (state_d == StError);
        end
    end

    assign bus.inst_mem_wr_en = wr_en_q;
    assign bus.inst_mem_addr  = addr_q;
    assign bus.inst_mem_data  = data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized bench for prog_loader, checked every cycle against a
// queue-based model of the loader protocol.
module tb_prog_loader;
    localparam int unsigned MaxWords = 4;
    localparam logic [31:0] Halt     = 32'hFFFFFFFF;
    localparam logic [7:0]  Cmd      = 8'h4C;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset, busy, done, err;

    prog_loader_if bus ();

    prog_loader #(
        .MAX_WORDS(MaxWords),
        .HALT_WORD(Halt),
        .CMD_LOAD (Cmd)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collected bytes, pending word, write pulse, mode
    typedef enum int {MIdle, MLoad, MDone, MErr} mmode_e;
    mmode_e      m_mode;
    logic [7:0]  m_bytes[$];
    int          m_words;
    bit          m_pend;
    logic [31:0] m_pend_word;
    logic        m_wr;
    logic [31:0] m_addr, m_data;

    task automatic model_reset();
        m_mode = MIdle;
        m_bytes.delete();
        m_words = 0;
        m_pend = 0;
        m_pend_word = '0;
        m_wr = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic   was_wr;
        mmode_e nxt;
        was_wr = m_wr;
        m_wr = 1'b0;
        nxt = m_mode;
        if (m_mode == MLoad) begin
            if (was_wr && m_data == Halt) nxt = MDone;
            else if (was_wr && m_words == int'(MaxWords)) nxt = MErr;
            if (m_pend) begin
                m_wr = 1'b1;
                m_addr = 32'(m_words * 4);
                m_data = m_pend_word;
                m_words++;
                m_pend = 0;
            end
            if (v) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 4) begin
                    m_pend = 1;
                    m_pend_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_bytes.delete();
                end
            end
            if (nxt != MLoad) begin
                m_bytes.delete();
                m_pend = 0;
            end
            m_mode = nxt;
        end else if (v && d == Cmd) begin
            m_mode = MLoad;
            m_bytes.delete();
            m_words = 0;
            m_pend = 0;
            m_addr = '0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step(bus.rx_valid, bus.rx_data);
    end

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(negedge clk) begin
        check("wr_en", 32'(bus.inst_mem_wr_en), 32'(m_wr));
        check("addr", bus.inst_mem_addr, m_addr);
        check("data", bus.inst_mem_data, m_data);
        check("status{cpu_reset,busy,done,err}", {28'd0, cpu_reset, busy, done, err},
              {28'd0, m_mode != MDone, m_mode == MLoad, m_mode == MDone, m_mode == MErr});
        if (bus.inst_mem_wr_en === 1'b1) begin
            log_addr.push_back(bus.inst_mem_addr);
            log_data.push_back(bus.inst_mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic check_reset_values();
        check("rst_wr_en", 32'(bus.inst_mem_wr_en), 32'd0);
        check("rst_addr", bus.inst_mem_addr, 32'd0);
        check("rst_data", bus.inst_mem_data, 32'd0);
        check("rst_status", {28'd0, cpu_reset, busy, done, err}, 32'b1000);
    endtask

    task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < log_addr.size()) begin
            check($sformatf("wr%0d_addr", idx), log_addr[idx], a);
            check($sformatf("wr%0d_data", idx), log_data[idx], d);
        end else begin
            check($sformatf("wr%0d_present", idx), 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        idle(2);
        check_reset_values();
        reset = 1'b1;
        idle(2);

        // Basic load: one instruction plus HALT
        clear_log();
        send(Cmd);
        check("load_busy", 32'(busy), 32'd1);
        send_word(32'h00094100);
        send_word(Halt);
        idle(3);
        check("t1_nwr", 32'(log_addr.size()), 32'd2);
        check_write(0, 32'd0, 32'h00094100);
        check_write(1, 32'd4, Halt);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);

        // Back-to-back bytes, 3 words + HALT (HALT lands in the last slot)
        clear_log();
        send(Cmd);
        send_word(32'h11223344);
        send_word(32'h4C4C4C4C);
        send_word(32'hA5B6C7D8);
        send_word(Halt);
        idle(3);
        check("t2_nwr", 32'(log_addr.size()), 32'd4);
        check_write(0, 32'd0, 32'h11223344);
        check_write(1, 32'd4, 32'h4C4C4C4C);
        check_write(2, 32'd8, 32'hA5B6C7D8);
        check_write(3, 32'd12, Halt);
        check("t2_done", 32'(done), 32'd1);

        // Overflow: MaxWords non-HALT words
        clear_log();
        send(Cmd);
        for (int i = 0; i < int'(MaxWords); i++) send_word(32'h01000000 + 32'(i));
        idle(3);
        check("t3_nwr", 32'(log_addr.size()), 32'(MaxWords));
        check_write(int'(MaxWords) - 1, 32'((MaxWords - 1) * 4), 32'h01000000 + 32'(MaxWords - 1));
        check("t3_err", 32'(err), 32'd1);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        send(Cmd);
        check("t3_err_clear", 32'(err), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);

        // Async reset, then junk bytes in IDLE
        reset = 1'b0;
        #1;
        check_reset_values();
        tick();
        reset = 1'b1;
        clear_log();
        send(8'h00);
        send(8'h12);
        send(8'hFF);
        idle(2);
        check("t4_nwr", 32'(log_addr.size()), 32'd0);
        check("t4_status", {28'd0, cpu_reset, busy, done, err}, 32'b1000);

        // Reset mid-way through the second word
        send(Cmd);
        send_word(32'hDEADBEEF);
        send(8'h12);
        send(8'h34);
        #1;
        reset = 1'b0;
        #1;
        check_reset_values();
        tick();
        reset = 1'b1;
        clear_log();
        send(Cmd);
        send_word(32'hCAFEF00D);
        send_word(Halt);
        idle(3);
        check_write(0, 32'd0, 32'hCAFEF00D);
        check("t5_done", 32'(done), 32'd1);

        // Reload from DONE
        clear_log();
        send(Cmd);
        check("t6_cpu_reset_load", 32'(cpu_reset), 32'd1);
        send_word(32'h3C080001);
        send_word(Halt);
        idle(3);
        check_write(0, 32'd0, 32'h3C080001);
        check_write(1, 32'd4, Halt);
        check("t6_release", {30'd0, cpu_reset, done}, 32'b01);

        // Randomized loads with gaps, embedded command bytes, overflows and resets
        for (int it = 0; it < 40; it++) begin
            int nwords;
            logic [31:0] w;
            nwords = $urandom_range(0, 6);
            repeat ($urandom_range(0, 3)) send(8'($urandom));
            send(Cmd);
            for (int k = 0; k < nwords; k++) begin
                w = ($urandom_range(0, 3) == 0) ? Halt : $urandom;
                for (int b = 3; b >= 0; b--) begin
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                    send(w[b*8 +: 8]);
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
